// File: rtl/percept_tx_arbiter.sv
// percept_tx_arbiter: round-robin owner of the single UART transmit byte path.
// Each granted packet is sent as one address header byte (BASE_ADDR+index)
// followed by the owner's payload, which is passed through combinationally.
// A packet ends on the owner's last byte or is cut after MAX_LEN payload bytes.
module percept_tx_arbiter #(
    parameter int NUM       = 3,
    parameter int BASE_ADDR = 100,
    parameter int MAX_LEN   = 16
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic [NUM-1:0]   req_valid,
    input  logic [8*NUM-1:0] req_data,
    input  logic [NUM-1:0]   req_last,
    output logic [NUM-1:0]   req_ready,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [NUM-1:0]   grant,
    output logic             busy,
    output logic             err_overrun
);

    localparam int IW = (NUM > 1) ? $clog2(NUM) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR  = 2'd1;
    localparam logic [1:0] S_PAY  = 2'd2;

    logic [1:0]           state;
    logic [IW-1:0]        owner;
    logic [IW-1:0]        rr;
    logic [7:0]           count;
    logic [NUM-1:0][7:0]  data_arr;
    logic [IW-1:0]        pick;
    logic [IW-1:0]        hi_pick;
    logic [IW-1:0]        lo_pick;
    logic                 hi_found;
    logic [IW-1:0]        rr_next;
    logic                 pay_fire;
    logic                 pay_end;

    // Unpack the flat byte bus into one byte per requester.
    for (genvar i = 0; i < NUM; i++) begin : g_unpack
        assign data_arr[i] = req_data[8*i +: 8];
    end

    // Round-robin pick: lowest requester at or above rr, else lowest below rr.
    // The scan runs downward so the final hit in each half is the lowest index.
    always_comb begin
        hi_found = 1'b0;
        hi_pick  = '0;
        lo_pick  = '0;
        for (int i = NUM - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                if (IW'(i) >= rr) begin
                    hi_found = 1'b1;
                    hi_pick  = IW'(i);
                end else begin
                    lo_pick = IW'(i);
                end
            end
        end
        pick = hi_found ? hi_pick : lo_pick;
    end

    assign rr_next  = (owner == IW'(NUM - 1)) ? '0 : owner + 1'b1;
    assign pay_fire = (state == S_PAY) && req_valid[owner] && tx_ready;
    assign pay_end  = req_last[owner] || (count == 8'(MAX_LEN - 1));

    // Packet sequencing, round-robin pointer, payload count and overrun pulse.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state       <= S_IDLE;
            owner       <= '0;
            rr          <= '0;
            count       <= '0;
            err_overrun <= 1'b0;
        end else begin
            err_overrun <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (|req_valid) begin
                        owner <= pick;
                        state <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (tx_ready) begin
                        state <= S_PAY;
                        count <= '0;
                    end
                end
                S_PAY: begin
                    if (pay_fire) begin
                        count <= count + 8'd1;
                        if (pay_end) begin
                            state       <= S_IDLE;
                            rr          <= rr_next;
                            // A cut packet leaves its remaining bytes pending.
                            err_overrun <= !req_last[owner];
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy  = (state != S_IDLE);
    assign grant = busy ? (NUM'(1) << owner) : '0;

    // Transmit path: header byte from the owner index, payload straight through.
    always_comb begin
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        req_ready = '0;
        case (state)
            S_HDR: begin
                tx_valid = 1'b1;
                tx_data  = 8'(BASE_ADDR) + 8'(owner);
            end
            S_PAY: begin
                tx_valid         = req_valid[owner];
                tx_data          = data_arr[owner];
                req_ready[owner] = tx_ready;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_percept_tx_arbiter.sv
// Bench for percept_tx_arbiter: packet-level reference model with per-requester
// byte queues, cycle-by-cycle output comparison, and literal byte-stream pins.
module tb_percept_tx_arbiter;

    localparam int NUM  = 3;
    localparam int BASE = 100;
    localparam int MAXL = 16;

    typedef struct packed {
        logic [7:0] d;
        logic       last;
    } ent_t;

    logic             clk = 1'b0;
    logic             nRst;
    logic [NUM-1:0]   req_valid;
    logic [8*NUM-1:0] req_data;
    logic [NUM-1:0]   req_last;
    logic [NUM-1:0]   req_ready;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [NUM-1:0]   grant;
    logic             busy;
    logic             err_overrun;

    percept_tx_arbiter #(.NUM(NUM), .BASE_ADDR(BASE), .MAX_LEN(MAXL)) dut (
        .clk(clk), .nRst(nRst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .grant(grant), .busy(busy), .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    // Stimulus source and model state.
    ent_t           q[NUM][$];
    logic [NUM-1:0] vld;
    int             vld_pct  = 100;
    int             rdy_mode = 0;
    int             m_own    = -1;   // packet owner, -1 when no packet
    bit             m_hdr    = 0;    // header still to be sent
    int             m_cnt    = 0;    // payload bytes sent in this packet
    int             m_ptr    = 0;    // requester searched first
    bit             m_err    = 0;
    logic [7:0]     txlog[$];
    logic [7:0]     exp_log[$];
    int             n_ovr = 0;
    int             n_cmp = 0;
    int             n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic last);
        ent_t e;
        e.d = d;
        e.last = last;
        q[r].push_back(e);
    endtask

    function automatic bit all_done();
        bit d = (m_own < 0);
        for (int i = 0; i < NUM; i++) if (q[i].size() != 0) d = 0;
        return d;
    endfunction

    // Expected outputs follow from who owns the path and whether the header is out.
    task automatic compare_outputs();
        logic           e_valid = 1'b0;
        logic [7:0]     e_data  = 8'h00;
        logic [NUM-1:0] e_ready = '0;
        logic [NUM-1:0] e_grant = '0;
        logic           e_busy  = 1'b0;
        if (nRst && m_own >= 0) begin
            e_busy  = 1'b1;
            e_grant = NUM'(1) << m_own;
            if (m_hdr) begin
                e_valid = 1'b1;
                e_data  = 8'((BASE + m_own) % 256);
            end else begin
                e_valid = vld[m_own];
                e_data  = vld[m_own] ? q[m_own][0].d : 8'h00;
                e_ready = NUM'(tx_ready) << m_own;
            end
        end
        chk("tx_valid", 32'(tx_valid), 32'(e_valid));
        chk("tx_data", 32'(tx_data), 32'(e_data));
        chk("req_ready", 32'(req_ready), 32'(e_ready));
        chk("grant", 32'(grant), 32'(e_grant));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("err_overrun", 32'(err_overrun), 32'(m_err && nRst));
    endtask

    // Advance the model across one rising edge using this cycle's handshakes.
    task automatic model_update();
        bit lst;
        if (!nRst) begin
            m_own = -1; m_hdr = 0; m_cnt = 0; m_ptr = 0; m_err = 0;
            return;
        end
        m_err = 0;
        if (m_own < 0) begin
            for (int k = 0; k < NUM; k++) begin
                int i = (m_ptr + k) % NUM;
                if (m_own < 0 && vld[i]) begin
                    m_own = i;
                    m_hdr = 1;
                end
            end
        end else if (m_hdr) begin
            if (tx_ready) begin
                m_hdr = 0;
                m_cnt = 0;
            end
        end else if (vld[m_own] && tx_ready) begin
            lst = q[m_own][0].last;
            void'(q[m_own].pop_front());
            vld[m_own] = 1'b0;
            m_cnt++;
            if (lst || m_cnt == MAXL) begin
                m_err = !lst;
                m_ptr = (m_own + 1) % NUM;
                m_own = -1;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        for (int i = 0; i < NUM; i++) begin
            if (!vld[i] && q[i].size() > 0 && ($urandom_range(99) < 32'(vld_pct)))
                vld[i] = 1'b1;
            req_valid[i]        = vld[i];
            req_data[8*i +: 8]  = vld[i] ? q[i][0].d : 8'h00;
            req_last[i]         = vld[i] ? q[i][0].last : 1'b0;
        end
        case (rdy_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = ~tx_ready;
            default: tx_ready = 1'($urandom_range(1));
        endcase
        #1;
        compare_outputs();
        if (tx_valid === 1'b1 && tx_ready) txlog.push_back(tx_data);
        if (err_overrun === 1'b1) n_ovr++;
        @(posedge clk);
        model_update();
    endtask

    task automatic drain(input string nm, input int max_cyc);
        int c = 0;
        while (!all_done() && c < max_cyc) begin
            step();
            c++;
        end
        chk(nm, 32'(all_done()), 32'd1);
    endtask

    task automatic do_reset();
        #2 nRst = 1'b0;
        repeat (2) step();
        #2 nRst = 1'b1;
    endtask

    task automatic check_log(input string nm);
        chk({nm, "_len"}, 32'(txlog.size()), 32'(exp_log.size()));
        for (int i = 0; i < exp_log.size(); i++)
            chk(nm, (i < txlog.size()) ? 32'(txlog[i]) : 32'hxxxx_xxxx, 32'(exp_log[i]));
        txlog.delete();
        exp_log.delete();
    endtask

    initial begin
        nRst = 1'b0; tx_ready = 1'b0; vld = '0;
        req_valid = '0; req_data = '0; req_last = '0;
        #1;
        chk("rst_tx_valid", 32'(tx_valid), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err_overrun), 0);
        repeat (2) step();
        #2 nRst = 1'b1;

        // Single 3-byte packet from requester 0.
        push(0, 8'hAA, 0); push(0, 8'hBB, 0); push(0, 8'hCC, 1);
        drain("p1_drain", 50);
        exp_log.push_back(8'h64); exp_log.push_back(8'hAA);
        exp_log.push_back(8'hBB); exp_log.push_back(8'hCC);
        check_log("p1_bytes");

        // All three valid from reset with 1-byte packets, then wrap to 0.
        do_reset();
        txlog.delete();
        push(0, 8'h11, 1); push(1, 8'h22, 1); push(2, 8'h33, 1);
        drain("p2_drain", 50);
        exp_log.push_back(8'h64); exp_log.push_back(8'h11);
        exp_log.push_back(8'h65); exp_log.push_back(8'h22);
        exp_log.push_back(8'h66); exp_log.push_back(8'h33);
        check_log("p2_order");
        push(0, 8'h44, 1); push(1, 8'h55, 1);
        drain("p2w_drain", 50);
        exp_log.push_back(8'h64); exp_log.push_back(8'h44);
        exp_log.push_back(8'h65); exp_log.push_back(8'h55);
        check_log("p2_wrap");

        // tx_ready toggling every cycle during a 4-byte packet.
        rdy_mode = 1;
        for (int j = 0; j < 4; j++) push(0, 8'(8'hD0 + j), j == 3);
        drain("p3_drain", 80);
        exp_log.push_back(8'h64);
        for (int j = 0; j < 4; j++) exp_log.push_back(8'(8'hD0 + j));
        check_log("p3_bytes");

        // 20 bytes from requester 1: cut at 16, remainder is a new packet.
        rdy_mode = 0;
        n_ovr = 0;
        for (int j = 0; j < 20; j++) push(1, 8'(8'h80 + j), j == 19);
        drain("p4_drain", 100);
        exp_log.push_back(8'h65);
        for (int j = 0; j < 16; j++) exp_log.push_back(8'(8'h80 + j));
        exp_log.push_back(8'h65);
        for (int j = 16; j < 20; j++) exp_log.push_back(8'(8'h80 + j));
        check_log("p4_bytes");
        chk("p4_overrun_pulses", 32'(n_ovr), 1);

        // Reset in the middle of a payload after two bytes.
        begin
            int c = 0;
            for (int j = 0; j < 5; j++) push(0, 8'(8'hE0 + j), j == 4);
            while (!(m_own == 0 && !m_hdr && m_cnt == 2) && c < 20) begin
                step();
                c++;
            end
            chk("p5_reached_pay", 32'(m_cnt), 2);
        end
        #2 nRst = 1'b0;
        #1;
        chk("p5_tx_valid", 32'(tx_valid), 0);
        chk("p5_req_ready", 32'(req_ready), 0);
        chk("p5_grant", 32'(grant), 0);
        chk("p5_busy", 32'(busy), 0);
        repeat (2) step();
        txlog.delete();
        #2 nRst = 1'b1;
        drain("p5_drain", 50);
        exp_log.push_back(8'h64);
        exp_log.push_back(8'hE2); exp_log.push_back(8'hE3); exp_log.push_back(8'hE4);
        check_log("p5_bytes");

        // Requester 2 arrives mid-packet and waits for requester 0 to finish.
        for (int j = 0; j < 6; j++) push(0, 8'(8'hF0 + j), j == 5);
        repeat (3) step();
        push(2, 8'h77, 1);
        drain("p6_drain", 60);
        exp_log.push_back(8'h64);
        for (int j = 0; j < 6; j++) exp_log.push_back(8'(8'hF0 + j));
        exp_log.push_back(8'h66); exp_log.push_back(8'h77);
        check_log("p6_bytes");

        // Random traffic: random owners, lengths past MAX_LEN, random stalls.
        rdy_mode = 2;
        vld_pct  = 50;
        for (int p = 0; p < 40; p++) begin
            int r = int'($urandom_range(NUM - 1));
            int n = int'($urandom_range(20, 1));
            for (int j = 0; j < n; j++) push(r, 8'($urandom), j == n - 1);
        end
        drain("p7_drain", 20000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
